// File: rtl/packet_parser_gen.sv
// packet_parser_gen: ingress Ethernet/IPv4 header parser.
// Consumes a big-endian beat stream (BUS_BYTES bytes per beat, first byte in
// the top lane) and produces the 120-bit packet header summary
// {8'h06, tos, src_port, dst_port, protocol, src_ip, dst_ip}.
// Handles 802.1Q tags, IPv4 options, UDP/TCP L4 headers, drops non-IPv4
// frames, flags malformed headers and reports the L4 payload length.
//
// Ports:
//   CLK, reset          clock, synchronous active-high reset
//   bus_i               beat data, bits [8*BUS_BYTES-1 -: 8] = lowest offset
//   bus_valid_i         beat qualifier
//   start_of_packet_i   first beat of a frame (qualified by bus_valid_i)
//   phs_o               header summary, held until the next summary
//   phs_valid_o         one-cycle pulse, summary complete
//   vlan_o              frame carried an 802.1Q tag (valid with phs_valid_o)
//   err_o               one-cycle pulse, malformed header
//   pkt_done_o          one-cycle pulse after the last IPv4 byte
//   pay_len_o           L4 payload byte count (valid with pkt_done_o)
//   state_o             current parser state (debug)
//
// Handshake: a beat is consumed in every cycle where bus_valid_i is high;
// there is no backpressure. A beat with start_of_packet_i restarts parsing
// at offset 0 whatever the current state. Output pulses are registered and
// appear in the cycle after the beat that caused them.
module packet_parser_gen #(
  parameter int BUS_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [8*BUS_BYTES-1:0] bus_i,
  input  logic                   bus_valid_i,
  input  logic                   start_of_packet_i,
  output logic [119:0]           phs_o,
  output logic                   phs_valid_o,
  output logic                   vlan_o,
  output logic                   err_o,
  output logic                   pkt_done_o,
  output logic [15:0]            pay_len_o,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L2   = 3'd1,
    S_L3   = 3'd2,
    S_L4   = 3'd3,
    S_PAY  = 3'd4,
    S_DROP = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_n, base;
  logic             vlan, vlan_n;
  logic [15:0]      etype, etype_n, tot_len, tot_len_n;
  logic [15:0]      sport, sport_n, dport, dport_n;
  logic [3:0]       ihl, ihl_n, doff, doff_n;
  logic [7:0]       tos, tos_n, proto, proto_n;
  logic [31:0]      sip, sip_n, dip, dip_n;

  logic             sop, fire_phs, fire_err, fire_done;
  logic [15:0]      pay_n;

  // Per-lane scratch: absolute offset, offset relative to L3 and to L4.
  logic [31:0]      off, rel, rel4;
  logic [7:0]       b;
  logic [15:0]      hl, l4len;
  logic [16:0]      hdr;

  assign sop     = bus_valid_i & start_of_packet_i;
  assign base    = sop ? '0 : byte_cnt;
  assign state_o = state;

  // Lanes are walked in order with the parse context updated byte by byte,
  // so a field captured in an early lane (VLAN, IHL, protocol) already
  // steers the later lanes of the same beat.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    vlan_n     = vlan;
    etype_n    = etype;
    tot_len_n  = tot_len;
    sport_n    = sport;
    dport_n    = dport;
    ihl_n      = ihl;
    doff_n     = doff;
    tos_n      = tos;
    proto_n    = proto;
    sip_n      = sip;
    dip_n      = dip;
    fire_phs   = 1'b0;
    fire_err   = 1'b0;
    fire_done  = 1'b0;
    pay_n      = '0;
    off        = '0;
    rel        = '0;
    rel4       = '0;
    b          = '0;
    hl         = '0;
    l4len      = '0;
    hdr        = '0;
    if (bus_valid_i) begin
      byte_cnt_n = base + CNT_W'(BUS_BYTES);
      if (sop) begin
        state_n   = S_L2;
        vlan_n    = 1'b0;
        etype_n   = '0;
        tot_len_n = '0;
        sport_n   = '0;
        dport_n   = '0;
        ihl_n     = '0;
        doff_n    = '0;
        tos_n     = '0;
        proto_n   = '0;
        sip_n     = '0;
        dip_n     = '0;
      end
      for (int k = 0; k < BUS_BYTES; k++) begin
        off   = 32'(base) + 32'(k);
        b     = bus_i[8*(BUS_BYTES-k)-1 -: 8];
        rel   = off - (vlan_n ? 32'd18 : 32'd14);
        hl    = {10'd0, ihl_n, 2'b00};
        rel4  = rel - {16'd0, hl};
        l4len = (proto_n == 8'd17) ? 16'd8 :
                (proto_n == 8'd6)  ? {10'd0, doff_n, 2'b00} : 16'd0;
        case (state_n)
          S_L2: begin
            if (off == 32'd12 || (vlan_n && off == 32'd16)) etype_n[15:8] = b;
            if (off == 32'd13 || (vlan_n && off == 32'd17)) begin
              etype_n[7:0] = b;
              if (off == 32'd13 && {etype_n[15:8], b} == 16'h8100) vlan_n = 1'b1;
            end
            if (off == (vlan_n ? 32'd17 : 32'd13))
              state_n = (etype_n == 16'h0800) ? S_L3 : S_DROP;
          end
          S_L3: begin
            case (rel)
              32'd0: begin
                ihl_n = b[3:0];
                if (b[7:4] != 4'd4 || b[3:0] < 4'd5) begin
                  fire_err = 1'b1;
                  state_n  = S_DROP;
                end
              end
              32'd1:  tos_n          = b;
              32'd2:  tot_len_n[15:8] = b;
              32'd3:  tot_len_n[7:0]  = b;
              32'd9:  proto_n        = b;
              32'd12: sip_n[31:24]   = b;
              32'd13: sip_n[23:16]   = b;
              32'd14: sip_n[15:8]    = b;
              32'd15: sip_n[7:0]     = b;
              32'd16: dip_n[31:24]   = b;
              32'd17: dip_n[23:16]   = b;
              32'd18: dip_n[15:8]    = b;
              32'd19: dip_n[7:0]     = b;
              default: ;
            endcase
            // Options between byte 20 and 4*IHL-1 are simply not captured.
            if (state_n == S_L3 && rel == 32'({ihl_n, 2'b00}) - 32'd1) begin
              if (proto_n == 8'd6 || proto_n == 8'd17) begin
                state_n = S_L4;
              end else begin
                sport_n  = '0;
                dport_n  = '0;
                fire_phs = 1'b1;
                state_n  = S_PAY;
              end
            end
          end
          S_L4: begin
            case (rel4)
              32'd0: sport_n[15:8] = b;
              32'd1: sport_n[7:0]  = b;
              32'd2: dport_n[15:8] = b;
              32'd3: dport_n[7:0]  = b;
              32'd12: begin
                if (proto_n == 8'd6) begin
                  doff_n = b[7:4];
                  if (b[7:4] < 4'd5) begin
                    fire_err = 1'b1;
                    state_n  = S_DROP;
                  end
                end
              end
              default: ;
            endcase
            if (state_n == S_L4 && rel4 == ((proto_n == 8'd17) ? 32'd7 : 32'd19)) begin
              fire_phs = 1'b1;
              state_n  = S_PAY;
            end
          end
          default: ;
        endcase
        // ">=" also closes a packet whose totalLength ended inside the header.
        if (state_n == S_PAY && rel + 32'd1 >= 32'(tot_len_n)) begin
          fire_done = 1'b1;
          state_n   = S_IDLE;
          hdr       = {1'b0, hl} + {1'b0, l4len};
          if ({1'b0, tot_len_n} < hdr) begin
            fire_err = 1'b1;
            pay_n    = '0;
          end else begin
            pay_n = tot_len_n - hl - l4len;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      vlan        <= 1'b0;
      etype       <= '0;
      tot_len     <= '0;
      sport       <= '0;
      dport       <= '0;
      ihl         <= '0;
      doff        <= '0;
      tos         <= '0;
      proto       <= '0;
      sip         <= '0;
      dip         <= '0;
      phs_o       <= '0;
      phs_valid_o <= 1'b0;
      vlan_o      <= 1'b0;
      err_o       <= 1'b0;
      pkt_done_o  <= 1'b0;
      pay_len_o   <= '0;
    end else begin
      state       <= state_n;
      byte_cnt    <= byte_cnt_n;
      vlan        <= vlan_n;
      etype       <= etype_n;
      tot_len     <= tot_len_n;
      sport       <= sport_n;
      dport       <= dport_n;
      ihl         <= ihl_n;
      doff        <= doff_n;
      tos         <= tos_n;
      proto       <= proto_n;
      sip         <= sip_n;
      dip         <= dip_n;
      phs_valid_o <= fire_phs;
      err_o       <= fire_err;
      pkt_done_o  <= fire_done;
      if (fire_phs) begin
        phs_o  <= {8'h06, tos_n, sport_n, dport_n, proto_n, sip_n, dip_n};
        vlan_o <= vlan_n;
      end
      if (fire_done) pay_len_o <= pay_n;
    end
  end

endmodule
